// File: rtl/ram_arbiter.sv
// Arbitrates the single-port data RAM between instruction fetch (read-only) and load/store.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise fixed MEM priority with IF starvation guard.
module ram_arbiter #(
   parameter logic [31:0] ADDR_LIMIT      = 32'h0004_0000,
   parameter int unsigned IF_STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [2:0]  mem_wtype,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_gnt,
   output logic        mem_rvalid,
   output logic [31:0] mem_rdata,
   output logic        mem_err,
   output logic        ram_we,
   output logic [2:0]  ram_wtype,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   logic [1:0] state, state_d;
   logic       pick_if_c, pick_mem_c;
   logic       if_fault_c, mem_fault_c;
   logic       acc_we, acc_fault, acc_mem;

`ifdef RAM_ARB_RR_EN
   logic       rr_mem_first;
`else
   localparam int unsigned STARVE_W = $clog2(IF_STARVE_LIMIT + 1);
   logic [STARVE_W-1:0] starve_cnt;
`endif

   // Fault checks on the raw request fields; only stores care about alignment on the MEM side.
   always_comb begin
      if_fault_c  = (if_addr >= ADDR_LIMIT) || (if_addr[1:0] != 2'b00);
      mem_fault_c = (mem_addr >= ADDR_LIMIT) ||
                    (mem_we && ((mem_wtype == 3'b001 && mem_addr[0]) ||
                                (mem_wtype == 3'b010 && mem_addr[1:0] != 2'b00) ||
                                (mem_wtype > 3'b010)));
   end

   always_comb begin
      state_d    = state;
      pick_if_c  = 1'b0;
      pick_mem_c = 1'b0;
      case (state)
         IDLE: begin
            if (if_req || mem_req) begin
               state_d = ACCESS;
               if (if_req && mem_req) begin
`ifdef RAM_ARB_RR_EN
                  pick_if_c = !rr_mem_first;
`else
                  pick_if_c = (starve_cnt == STARVE_W'(IF_STARVE_LIMIT));
`endif
                  pick_mem_c = !pick_if_c;
               end else begin
                  pick_if_c  = if_req;
                  pick_mem_c = mem_req;
               end
            end
         end
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   // Access latch, grant/response pulses and RAM drive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_gnt     <= 1'b0;
         if_rvalid  <= 1'b0;
         if_rdata   <= 32'h0;
         if_err     <= 1'b0;
         mem_gnt    <= 1'b0;
         mem_rvalid <= 1'b0;
         mem_rdata  <= 32'h0;
         mem_err    <= 1'b0;
         ram_we     <= 1'b0;
         ram_wtype  <= 3'b000;
         ram_addr   <= 32'h0;
         ram_wdata  <= 32'h0;
         acc_we     <= 1'b0;
         acc_fault  <= 1'b0;
         acc_mem    <= 1'b0;
      end else begin
         if_gnt     <= pick_if_c;
         mem_gnt    <= pick_mem_c;
         if_rvalid  <= 1'b0;
         if_rdata   <= 32'h0;
         if_err     <= 1'b0;
         mem_rvalid <= 1'b0;
         mem_rdata  <= 32'h0;
         mem_err    <= 1'b0;
         ram_we     <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_if_c) begin
                  ram_addr  <= if_addr;
                  ram_wtype <= 3'b010;
                  ram_wdata <= 32'h0;
                  acc_we    <= 1'b0;
                  acc_fault <= if_fault_c;
                  acc_mem   <= 1'b0;
               end else if (pick_mem_c) begin
                  ram_addr  <= mem_addr;
                  ram_wtype <= mem_wtype;
                  ram_wdata <= mem_wdata;
                  ram_we    <= mem_we && !mem_fault_c;
                  acc_we    <= mem_we;
                  acc_fault <= mem_fault_c;
                  acc_mem   <= 1'b1;
               end
            end
            ACCESS: begin
               if (acc_mem) begin
                  mem_rvalid <= 1'b1;
                  mem_rdata  <= (acc_we || acc_fault) ? 32'h0 : ram_rdata;
                  mem_err    <= acc_fault;
               end else begin
                  if_rvalid  <= 1'b1;
                  if_rdata   <= acc_fault ? 32'h0 : ram_rdata;
                  if_err     <= acc_fault;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef RAM_ARB_RR_EN
   // After each grant the other requester wins the next collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             rr_mem_first <= 1'b1;
      else if (pick_if_c)  rr_mem_first <= 1'b1;
      else if (pick_mem_c) rr_mem_first <= 1'b0;
   end
`else
   // Counts MEM wins while IF is waiting; reaching the limit hands IF the next arbitration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      starve_cnt <= '0;
      else if (!if_req || pick_if_c) starve_cnt <= '0;
      else if (pick_mem_c)          starve_cnt <= starve_cnt + STARVE_W'(1);
   end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a big-endian byte-lane RAM model.
// Honours RAM_ARB_RR_EN for the expected arbitration order.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_rvalid, if_err;
   logic [31:0] if_rdata;
   logic        mem_req, mem_we;
   logic [2:0]  mem_wtype;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_gnt, mem_rvalid, mem_err;
   logic [31:0] mem_rdata;
   logic        ram_we;
   logic [2:0]  ram_wtype;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;

   logic [31:0] ram_model [0:255];
   int unsigned we_count = 0;
   int unsigned n_tests  = 0;
   int unsigned n_fail   = 0;

   ram_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_err(if_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_wtype(mem_wtype), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .mem_err(mem_err),
      .ram_we(ram_we), .ram_wtype(ram_wtype), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   assign ram_rdata = ram_model[ram_addr[9:2]];

   // Big-endian lanes: byte offset 0 is bits [31:24].
   always @(posedge clk) begin
      if (ram_we === 1'b1) begin
         we_count <= we_count + 1;
         case (ram_wtype)
            3'b000: case (ram_addr[1:0])
               2'd0: ram_model[ram_addr[9:2]][31:24] <= ram_wdata[7:0];
               2'd1: ram_model[ram_addr[9:2]][23:16] <= ram_wdata[7:0];
               2'd2: ram_model[ram_addr[9:2]][15:8]  <= ram_wdata[7:0];
               default: ram_model[ram_addr[9:2]][7:0] <= ram_wdata[7:0];
            endcase
            3'b001: if (ram_addr[1]) ram_model[ram_addr[9:2]][15:0]  <= ram_wdata[15:0];
                    else             ram_model[ram_addr[9:2]][31:16] <= ram_wdata[15:0];
            default: ram_model[ram_addr[9:2]] <= ram_wdata;
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mem_access(input string tag, input logic we, input logic [2:0] wt,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] exp_rd, input logic exp_err);
      int unsigned n;
      int unsigned we0;
      we0       = we_count;
      mem_req   = 1'b1;
      mem_we    = we;
      mem_wtype = wt;
      mem_addr  = addr;
      mem_wdata = wd;
      n = 0;
      do begin
         tick();
         n++;
      end while (!mem_gnt && n < 8);
      check({tag, "_gnt_lat"}, 32'(n), 32'd1);
      check({tag, "_ram_addr"}, ram_addr, addr);
      mem_req = 1'b0;
      tick();
      check({tag, "_rvalid"}, 32'(mem_rvalid), 32'd1);
      check({tag, "_rdata"}, mem_rdata, exp_rd);
      check({tag, "_err"}, 32'(mem_err), 32'(exp_err));
      check({tag, "_we_cycles"}, 32'(we_count - we0), 32'(we && !exp_err));
      tick();
      check({tag, "_rvalid_pulse"}, 32'(mem_rvalid), 32'd0);
   endtask

   task automatic if_access(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_rd, input logic exp_err);
      int unsigned n;
      if_req  = 1'b1;
      if_addr = addr;
      n = 0;
      do begin
         tick();
         n++;
      end while (!if_gnt && n < 8);
      check({tag, "_gnt_lat"}, 32'(n), 32'd1);
      check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
      if_req = 1'b0;
      tick();
      check({tag, "_rvalid"}, 32'(if_rvalid), 32'd1);
      check({tag, "_rdata"}, if_rdata, exp_rd);
      check({tag, "_err"}, 32'(if_err), 32'(exp_err));
      tick();
      check({tag, "_rvalid_pulse"}, 32'(if_rvalid), 32'd0);
   endtask

   initial begin
      logic [1:0] grants [0:9];
      logic [1:0] exp_g;
      int unsigned ng;

      for (int i = 0; i < 256; i++) ram_model[i] = 32'hC0DE_0000 | 32'(i);
      rst = 1'b1;
      if_req = 1'b0; if_addr = 32'h0;
      mem_req = 1'b0; mem_we = 1'b0; mem_wtype = 3'b000; mem_addr = 32'h0; mem_wdata = 32'h0;

      #12;
      check("rst_ctrl", 32'({if_gnt, if_rvalid, if_err, mem_gnt, mem_rvalid, mem_err, ram_we}), 32'd0);
      check("rst_rdata", if_rdata | mem_rdata, 32'h0);
      check("rst_ram", ram_addr | ram_wdata | 32'(ram_wtype), 32'h0);
      #10 rst = 1'b0;
      tick();

      if_access("if_word4", 32'h0000_0010, 32'hC0DE_0004, 1'b0);
      if_access("if_range", 32'h0004_0000, 32'h0, 1'b1);
      if_access("if_misalign", 32'h0000_0012, 32'h0, 1'b1);

      mem_access("st_byte", 1'b1, 3'b000, 32'h0000_0021, 32'h0000_00AB, 32'h0, 1'b0);
      mem_access("ld_byte", 1'b0, 3'b010, 32'h0000_0020, 32'h0, 32'hC0AB_0008, 1'b0);
      mem_access("st_w_mis", 1'b1, 3'b010, 32'h0000_0022, 32'hFFFF_FFFF, 32'h0, 1'b1);
      mem_access("st_wt011", 1'b1, 3'b011, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
      mem_access("st_h_mis", 1'b1, 3'b001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 1'b1);
      mem_access("st_range", 1'b1, 3'b010, 32'h0004_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
      mem_access("ld_unchg", 1'b0, 3'b010, 32'h0000_0000, 32'h0, 32'hC0DE_0000, 1'b0);
      mem_access("ld_mis_ok", 1'b0, 3'b010, 32'h0000_0023, 32'h0, 32'hC0AB_0008, 1'b0);
      mem_access("st_half", 1'b1, 3'b001, 32'h0000_0002, 32'h0000_1234, 32'h0, 1'b0);
      mem_access("ld_half", 1'b0, 3'b000, 32'h0000_0000, 32'h0, 32'hC0DE_1234, 1'b0);
      mem_access("ld_range", 1'b0, 3'b010, 32'h0004_0000, 32'h0, 32'h0, 1'b1);

      // Reset while a store is in ACCESS.
      mem_req = 1'b1; mem_we = 1'b1; mem_wtype = 3'b010;
      mem_addr = 32'h0000_0030; mem_wdata = 32'hDEAD_BEEF;
      tick();
      check("rst_mid_gnt", 32'(mem_gnt), 32'd1);
      check("rst_mid_we_pre", 32'(ram_we), 32'd1);
      mem_req = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rst_mid_we_async", 32'(ram_we), 32'd0);
      check("rst_mid_gnt_drop", 32'(mem_gnt), 32'd0);
      #3 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_mid_no_rvalid", 32'(mem_rvalid | if_rvalid), 32'd0);
      end
      mem_access("rst_mid_ld", 1'b0, 3'b010, 32'h0000_0030, 32'h0, 32'hC0DE_000C, 1'b0);
      if_access("if_after_rst", 32'h0000_0008, 32'hC0DE_0002, 1'b0);

      // Both requesters held high: record ten grants.
      if_req = 1'b1; if_addr = 32'h0000_0010;
      mem_req = 1'b1; mem_we = 1'b0; mem_wtype = 3'b010; mem_addr = 32'h0000_0020;
      ng = 0;
      for (int c = 0; c < 40 && ng < 10; c++) begin
         tick();
         if (if_gnt || mem_gnt) begin
            grants[ng] = {if_gnt, mem_gnt};
            ng++;
         end
      end
      if_req = 1'b0; mem_req = 1'b0;
      check("arb_count", 32'(ng), 32'd10);
      for (int i = 0; i < 10 && i < int'(ng); i++) begin
`ifdef RAM_ARB_RR_EN
         exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
         exp_g = (i % 5 == 4) ? 2'b10 : 2'b01;
`endif
         check($sformatf("arb_grant%0d", i), 32'(grants[i]), 32'(exp_g));
      end
      repeat (3) tick();
      check("idle_quiet", 32'({if_gnt, mem_gnt, if_rvalid, mem_rvalid, ram_we}), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
